// File: rtl/div_unit.sv
// ============================================================================
//  div_unit : 32-bit radix-2 restoring divider (MIPS DIV/DIVU), 33-cycle latency
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signed_div,
    input  logic        start,
    input  logic        cancel,
    output logic        stall,
    output logic        busy,
    output logic        ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_count;
    logic [31:0] r_divisor;
    logic [31:0] r_dq;
    logic [31:0] r_rem;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [63:0] r_result;

    logic        w_div0;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_next;
    logic [31:0] w_q_next;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_div0  = (b == 32'd0);
    assign w_a_mag = (signed_div && a[31]) ? (32'd0 - a) : a;
    assign w_b_mag = (signed_div && b[31]) ? (32'd0 - b) : b;

    // The held remainder is always below the divisor, so 32 bits plus the
    // incoming dividend bit form the 33-bit trial value.
    assign w_shift    = {r_rem, r_dq[31]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[32];
    assign w_rem_next = w_qbit ? w_diff[31:0] : w_shift[31:0];
    assign w_q_next   = {r_dq[30:0], w_qbit};
    assign w_q_fix    = r_sign_q ? (32'd0 - w_q_next)   : w_q_next;
    assign w_r_fix    = r_sign_r ? (32'd0 - w_rem_next) : w_rem_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = w_div0 ? S_FINISH : S_DIV;
            S_DIV:    if (r_count == 5'd31) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (cancel) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= 5'd0;
            r_divisor <= 32'd0;
            r_dq      <= 32'd0;
            r_rem     <= 32'd0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_result  <= 64'd0;
        end else begin
            r_state <= w_next;
            if (!cancel) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_div0) begin
                                r_result <= {a, 32'hFFFF_FFFF};
                            end else begin
                                r_divisor <= w_b_mag;
                                r_dq      <= w_a_mag;
                                r_rem     <= 32'd0;
                                r_count   <= 5'd0;
                                r_sign_q  <= signed_div & (a[31] ^ b[31]);
                                r_sign_r  <= signed_div & a[31];
                            end
                        end
                    end
                    S_DIV: begin
                        r_rem   <= w_rem_next;
                        r_dq    <= w_q_next;
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'd31) r_result <= {w_r_fix, w_q_fix};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign stall  = ((r_state == S_IDLE) && start && !cancel) || (r_state == S_DIV);
    assign busy   = (r_state == S_DIV);
    assign ready  = (r_state == S_FINISH);
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  tb_div_unit : directed self-checking bench for div_unit
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        signed_div = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        stall;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .signed_div (signed_div),
        .start      (start),
        .cancel     (cancel),
        .stall      (stall),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Issues one operation in cycle T and follows it until ready (bounded).
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isd,
                         output int lat, output int n_stall, output int n_busy,
                         output logic [63:0] res, output logic rdy_after,
                         output logic [63:0] res_after);
        lat = -1; n_stall = 0; n_busy = 0; res = 'x;
        @(negedge clk);
        a = ia; b = ib; signed_div = isd; start = 1'b1;
        #1;
        if (stall) n_stall++;
        if (busy)  n_busy++;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (busy)  n_busy++;
            if (ready) begin
                lat = k;
                res = result;
                break;
            end
        end
        @(negedge clk);
        rdy_after = ready;
        res_after = result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        rst = 1'b0;
    endtask

    task automatic test_divu_timing();
        int lat, ns, nb; logic [63:0] r, ra; logic rd;
        do_op(32'd100, 32'd7, 1'b0, lat, ns, nb, r, rd, ra);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", lat); end
        n_cmp++; if (ns !== 33) begin n_err++; $display("FAIL divu_stall_cycles: got %0d want 33", ns); end
        n_cmp++; if (nb !== 32) begin n_err++; $display("FAIL divu_busy_cycles: got %0d want 32", nb); end
        n_cmp++; if (r !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7: got %h want %h", r, {32'd2, 32'd14}); end
        n_cmp++; if (rd !== 1'b0) begin n_err++; $display("FAIL divu_ready_pulse: got %b want 0", rd); end
        n_cmp++; if (ra !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_result_hold: got %h want %h", ra, {32'd2, 32'd14}); end
    endtask

    task automatic test_signed();
        int lat, ns, nb; logic [63:0] r, ra; logic rd;
        logic [31:0] va [6]; logic [31:0] vb [6]; logic vs [6]; logic [63:0] ve [6];
        va[0] = 32'hFFFF_FFF9; vb[0] = 32'h2;         vs[0] = 1'b1; ve[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        va[1] = 32'h7;         vb[1] = 32'hFFFF_FFFE; vs[1] = 1'b1; ve[1] = {32'h1, 32'hFFFF_FFFD};
        va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; vs[2] = 1'b1; ve[2] = {32'h0, 32'h8000_0000};
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'h1;         vs[3] = 1'b0; ve[3] = {32'h0, 32'hFFFF_FFFF};
        va[4] = 32'hFFFF_FFF9; vb[4] = 32'hFFFF_FFFE; vs[4] = 1'b1; ve[4] = {32'hFFFF_FFFF, 32'h3};
        va[5] = 32'h8000_0000; vb[5] = 32'hFFFF_FFFF; vs[5] = 1'b0; ve[5] = {32'h8000_0000, 32'h0};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vs[i], lat, ns, nb, r, rd, ra);
            n_cmp++;
            if (r !== ve[i] || lat !== 33)
                begin n_err++; $display("FAIL arith_vec%0d: got %h lat %0d want %h lat 33", i, r, lat, ve[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat, ns, nb; logic [63:0] r, ra; logic rd;
        do_op(32'h1234, 32'h0, 1'b0, lat, ns, nb, r, rd, ra);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL div0_latency: got %0d want 1", lat); end
        n_cmp++; if (ns !== 1) begin n_err++; $display("FAIL div0_stall_cycles: got %0d want 1", ns); end
        n_cmp++; if (nb !== 0) begin n_err++; $display("FAIL div0_busy_cycles: got %0d want 0", nb); end
        n_cmp++; if (r !== {32'h1234, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL div0_result: got %h want %h", r, {32'h1234, 32'hFFFF_FFFF}); end
    endtask

    task automatic test_cancel(input logic [63:0] prev);
        int lat, ns, nb; logic [63:0] r, ra; logic rd;
        @(negedge clk);
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(negedge clk);
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL cancel_pre: got stall %b busy %b want 1 1", stall, busy); end
        cancel = 1'b1;
        @(posedge clk); #1 cancel = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || stall !== 1'b0 || ready !== 1'b0)
            begin n_err++; $display("FAIL cancel_post: got busy %b stall %b ready %b want 0 0 0", busy, stall, ready); end
        n_cmp++; if (result !== prev) begin n_err++; $display("FAIL cancel_result: got %h want %h", result, prev); end
        do_op(32'd20, 32'd3, 1'b0, lat, ns, nb, r, rd, ra);
        n_cmp++; if (lat !== 33 || r !== {32'd2, 32'd6})
            begin n_err++; $display("FAIL cancel_restart: got %h lat %0d want %h lat 33", r, lat, {32'd2, 32'd6}); end
    endtask

    task automatic test_reset_mid();
        int nr;
        @(negedge clk);
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || ready !== 1'b0 || stall !== 1'b0)
            begin n_err++; $display("FAIL rstmid_flags: got busy %b ready %b stall %b want 0 0 0", busy, ready, stall); end
        n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL rstmid_result: got %h want 0", result); end
        nr = 0;
        repeat (40) begin @(negedge clk); if (ready) nr++; end
        n_cmp++; if (nr !== 0) begin n_err++; $display("FAIL rstmid_no_ready: got %0d pulses want 0", nr); end
    endtask

    task automatic test_start_ignored();
        int lat; logic [63:0] r;
        lat = -1; r = 'x;
        @(negedge clk);
        a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a = 32'd9; b = 32'd3; signed_div = 1'b1; start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end else if (ready) begin
                lat = k; r = result;
                a = 32'd5; b = 32'd0; start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                break;
            end
        end
        n_cmp++; if (lat !== 33 || r !== {32'd0, 32'd100})
            begin n_err++; $display("FAIL ignore_in_div: got %h lat %0d want %h lat 33", r, lat, {32'd0, 32'd100}); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0 || result !== {32'd0, 32'd100})
            begin n_err++; $display("FAIL ignore_in_finish: got ready %b result %h want 0 %h", ready, result, {32'd0, 32'd100}); end
    endtask

    initial begin
        test_reset();
        test_divu_timing();
        test_signed();
        test_div_zero();
        test_cancel({32'h1234, 32'hFFFF_FFFF});
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
